// File: rtl/fm_hdmi_fmt_if.sv
// fm_hdmi_fmt_if: video-in / HDMI-out bundle for the pixel formatter.
// master drives the timing/pixel stream, slave is the formatter.
interface fm_hdmi_fmt_if #(
  parameter int DW = 8
) ();
  logic [1:0]      i_mode;
  logic            i_vsync;
  logic            i_hsync;
  logic            i_de;
  logic [DW-1:0]   i_r;
  logic [DW-1:0]   i_g;
  logic [DW-1:0]   i_b;
  logic            o_hd_vsync;
  logic            o_hd_hsync;
  logic            o_hd_de;
  logic [3*DW-1:0] o_hd_d;
  logic [1:0]      o_mode;

  modport master (
    output i_mode, i_vsync, i_hsync, i_de, i_r, i_g, i_b,
    input  o_hd_vsync, o_hd_hsync, o_hd_de, o_hd_d, o_mode
  );

  modport slave (
    input  i_mode, i_vsync, i_hsync, i_de, i_r, i_g, i_b,
    output o_hd_vsync, o_hd_hsync, o_hd_de, o_hd_d, o_mode
  );
endinterface

// File: rtl/fm_hdmi_fmt.sv
// fm_hdmi_fmt: RGB444 / YCC444 / YCC422 HDMI formatter, fixed 6-cycle latency.
// Define FM_HDMI_FMT_BLANK_EN to drive blanking data while output DE is low.
module fm_hdmi_fmt #(
  parameter int DW           = 8,
  parameter bit SYNC_ACTIVE  = 1'b0,
  parameter bit OUT_SYNC_INV = 1'b0
) (
  input logic          clk_v,
  input logic          rst,
  fm_hdmi_fmt_if.slave bus
);
  localparam int S = DW - 8;
  localparam int W = DW + 10;
  localparam logic [DW-1:0] Y_OFS = DW'(16 << S);
  localparam logic [DW-1:0] C_OFS = DW'(128 << S);
  localparam logic [DW-1:0] ZERO  = '0;
  localparam logic [DW-1:0] MAXV  = '1;
  localparam int K [9] = '{66, 129, 25, -38, -74, 112, 112, -94, -18};

  typedef struct packed {
    logic          de;
    logic          vs;
    logic          hs;
    logic [1:0]    mode;
    logic [DW-1:0] r;
    logic [DW-1:0] g;
    logic [DW-1:0] b;
  } px_t;

  px_t                 px_q [5];
  px_t                 px_d [5];
  logic signed [W-1:0] p_q [9];
  logic signed [W-1:0] p_d [9];
  logic signed [W-1:0] s_q [3];
  logic signed [W-1:0] s_d [3];
  logic [DW-1:0]       c4_q [3];
  logic [DW-1:0]       c4_d [3];
  logic [DW-1:0]       c5_q [3];
  logic [DW-1:0]       c5_d [3];
  logic                ph_q, ph_d;
  logic [DW-1:0]       crh_q, crh_d;
  logic                vsp_q, vsp_d;
  logic [1:0]          act_q, act_d;
  logic                de_q, de_d;
  logic                vs_q, vs_d;
  logic                hs_q, hs_d;
  logic [1:0]          mode_q, mode_d;
  logic [3*DW-1:0]     d_q, d_d;

  logic                vs_in;
  logic                hs_in;
  logic [1:0]          req;
  logic [DW-1:0]       c_ev;
  logic [DW-1:0]       c_od;
  px_t                 cur;

  function automatic logic signed [W-1:0] ext(
    input logic [DW-1:0] v
  );
    return signed'(W'(v));
  endfunction

  function automatic logic [DW-1:0] clamp(
    input logic signed [W-1:0] s,
    input logic [DW-1:0]       ofs
  );
    logic signed [W-1:0] v;
    v = (s >>> 8) + ext(ofs);
    if (v[W-1]) return '0;
    if (v > ext(MAXV)) return MAXV;
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] avg(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    logic [DW:0] t;
    t = {1'b0, a} + {1'b0, b} + (DW+1)'(1);
    return t[DW:1];
  endfunction

  always_comb begin
    vs_in = (bus.i_vsync == SYNC_ACTIVE);
    hs_in = (bus.i_hsync == SYNC_ACTIVE);
    req   = (bus.i_mode == 2'd3) ? 2'd0 : bus.i_mode;
    // a vsync leading edge latches the mode for this very pixel onward
    act_d = (vs_in && !vsp_q) ? req : act_q;
    vsp_d = vs_in;

    px_d[0].de   = bus.i_de;
    px_d[0].vs   = vs_in;
    px_d[0].hs   = hs_in;
    px_d[0].mode = act_d;
    px_d[0].r    = bus.i_r;
    px_d[0].g    = bus.i_g;
    px_d[0].b    = bus.i_b;
    for (int k = 1; k < 5; k++) px_d[k] = px_q[k-1];

    for (int i = 0; i < 9; i++) begin
      p_d[i] = ext((i % 3 == 0) ? px_q[0].r :
                   (i % 3 == 1) ? px_q[0].g : px_q[0].b)
             * W'(K[i]);
    end
    for (int j = 0; j < 3; j++) begin
      s_d[j]  = p_q[3*j] + p_q[3*j+1] + p_q[3*j+2] + W'(128);
      c4_d[j] = clamp(s_q[j], (j == 0) ? Y_OFS : C_OFS);
    end
    c5_d = c4_q;

    // stage 5 holds pixel n while stage 4 already has pixel n+1
    ph_d  = (px_q[3].de && px_q[4].de) ? ~ph_q : 1'b0;
    crh_d = c5_q[2];

    cur  = px_q[4];
    c_ev = px_q[3].de ? avg(c5_q[1], c4_q[1]) : c5_q[1];
    c_od = avg(crh_q, c5_q[2]);

    de_d   = cur.de;
    vs_d   = cur.vs;
    hs_d   = cur.hs;
    mode_d = cur.mode;
    d_d    = d_q;
    if (cur.de) begin
      unique case (cur.mode)
        2'd1:    d_d = {c5_q[2], c5_q[0], c5_q[1]};
        2'd2:    d_d = {ZERO, c5_q[0], ph_q ? c_od : c_ev};
        default: d_d = {cur.r, cur.g, cur.b};
      endcase
    end
`ifdef FM_HDMI_FMT_BLANK_EN
    else begin
      unique case (cur.mode)
        2'd1:    d_d = {C_OFS, Y_OFS, C_OFS};
        2'd2:    d_d = {ZERO, Y_OFS, C_OFS};
        default: d_d = '0;
      endcase
    end
`endif
  end

  always_ff @(posedge clk_v) begin
    if (rst) begin
      for (int k = 0; k < 5; k++) px_q[k] <= '0;
      for (int i = 0; i < 9; i++) p_q[i] <= '0;
      for (int j = 0; j < 3; j++) begin
        s_q[j]  <= '0;
        c4_q[j] <= '0;
        c5_q[j] <= '0;
      end
      ph_q   <= 1'b0;
      crh_q  <= '0;
      vsp_q  <= 1'b0;
      act_q  <= 2'd0;
      de_q   <= 1'b0;
      vs_q   <= 1'b0;
      hs_q   <= 1'b0;
      mode_q <= 2'd0;
      d_q    <= '0;
    end else begin
      px_q   <= px_d;
      p_q    <= p_d;
      s_q    <= s_d;
      c4_q   <= c4_d;
      c5_q   <= c5_d;
      ph_q   <= ph_d;
      crh_q  <= crh_d;
      vsp_q  <= vsp_d;
      act_q  <= act_d;
      de_q   <= de_d;
      vs_q   <= vs_d;
      hs_q   <= hs_d;
      mode_q <= mode_d;
      d_q    <= d_d;
    end
  end

  assign bus.o_hd_de    = de_q;
  assign bus.o_hd_vsync = (vs_q ? SYNC_ACTIVE : ~SYNC_ACTIVE) ^ OUT_SYNC_INV;
  assign bus.o_hd_hsync = (hs_q ? SYNC_ACTIVE : ~SYNC_ACTIVE) ^ OUT_SYNC_INV;
  assign bus.o_hd_d     = d_q;
  assign bus.o_mode     = mode_q;
endmodule

// File: tb/tb_fm_hdmi_fmt.sv
// tb_fm_hdmi_fmt: scoreboard bench for fm_hdmi_fmt with a line-level model.
// Expected outputs are queued at issue time and checked by a separate monitor.
module tb_fm_hdmi_fmt;
  localparam int DW  = 8;
  localparam int S   = DW - 8;
  localparam int L   = 6;
  localparam bit SA  = 1'b0;
  localparam bit INV = 1'b0;
  localparam int MX  = (1 << DW) - 1;

  typedef struct {
    bit       rst;
    bit       vs;
    bit       hs;
    bit       de;
    bit [1:0] mode;
    int       r;
    int       g;
    int       b;
  } st_t;

  typedef struct {
    int              due;
    bit              de;
    bit              vs;
    bit              hs;
    bit              chkd;
    bit [1:0]        mode;
    logic [3*DW-1:0] d;
  } ex_t;

  logic clk_v = 1'b0;
  logic rst   = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  st_t stim [$];
  ex_t exps [$];
  ex_t sb [$];

  fm_hdmi_fmt_if #(.DW(DW)) bus ();

  fm_hdmi_fmt #(
    .DW(DW),
    .SYNC_ACTIVE(SA),
    .OUT_SYNC_INV(INV)
  ) dut (
    .clk_v(clk_v),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk_v = ~clk_v;
  always @(posedge clk_v) cyc <= cyc + 1;

  task automatic add(input bit r_, input bit vs, input bit hs,
                     input bit de, input int m,
                     input int r, input int g, input int b);
    st_t s;
    s.rst  = r_;
    s.vs   = vs;
    s.hs   = hs;
    s.de   = de;
    s.mode = 2'(m);
    s.r    = r;
    s.g    = g;
    s.b    = b;
    stim.push_back(s);
  endtask

  task automatic idle(input int n, input int m);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, m, 0, 0, 0);
  endtask

  task automatic vpulse(input int n, input int m);
    for (int i = 0; i < n; i++) add(0, 1, 0, 0, m, 0, 0, 0);
  endtask

  task automatic rline(input int n, input int m);
    add(0, 0, 1, 0, m, 0, 0, 0);
    for (int i = 0; i < n; i++)
      add(0, 0, 0, 1, m, $urandom_range(0, MX),
          $urandom_range(0, MX), $urandom_range(0, MX));
  endtask

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > MX) return MX;
    return v;
  endfunction

  function automatic void ycc(input st_t s, output int y,
                              output int cb, output int cr);
    y  = clampi(((66*s.r + 129*s.g + 25*s.b + 128) >>> 8) + (16 << S));
    cb = clampi(((-38*s.r - 74*s.g + 112*s.b + 128) >>> 8) + (128 << S));
    cr = clampi(((112*s.r - 94*s.g - 18*s.b + 128) >>> 8) + (128 << S));
  endfunction

  task automatic build_exp();
    int act = 0;
    bit vp  = 0;
    int k   = 0;
    for (int i = 0; i < stim.size(); i++) begin
      st_t s;
      ex_t e;
      int  y, cb, cr, y2, cb2, cr2, c;
      s = stim[i];
      e.due  = 0;
      e.d    = '0;
      if (s.rst) begin
        act = 0;
        vp  = 0;
        k   = 0;
        e.de = 0; e.vs = 0; e.hs = 0; e.mode = 0; e.chkd = 1;
        exps.push_back(e);
        continue;
      end
      if (s.vs && !vp) act = (s.mode == 2'd3) ? 0 : int'(s.mode);
      vp = s.vs;
      e.de   = s.de;
      e.vs   = s.vs;
      e.hs   = s.hs;
      e.mode = 2'(act);
      e.chkd = s.de;
      if (s.de) begin
        ycc(s, y, cb, cr);
        if (act == 1) e.d = {DW'(cr), DW'(y), DW'(cb)};
        else if (act == 2) begin
          if (k % 2 == 0) begin
            c = cb;
            if (i + 1 < stim.size() && !stim[i+1].rst && stim[i+1].de) begin
              ycc(stim[i+1], y2, cb2, cr2);
              c = (cb + cb2 + 1) / 2;
            end
          end else begin
            ycc(stim[i-1], y2, cb2, cr2);
            c = (cr2 + cr + 1) / 2;
          end
          e.d = {DW'(0), DW'(y), DW'(c)};
        end
        else e.d = {DW'(s.r), DW'(s.g), DW'(s.b)};
        k++;
      end else begin
        k = 0;
`ifdef FM_HDMI_FMT_BLANK_EN
        e.chkd = 1;
        if (act == 1) e.d = {DW'(128 << S), DW'(16 << S), DW'(128 << S)};
        else if (act == 2) e.d = {DW'(0), DW'(16 << S), DW'(128 << S)};
        else e.d = '0;
`endif
      end
      exps.push_back(e);
    end
  endtask

  task automatic chk(input ex_t e);
    logic xv, xh;
    bit   bad;
    xv  = (e.vs ? SA : ~SA) ^ INV;
    xh  = (e.hs ? SA : ~SA) ^ INV;
    bad = (bus.o_hd_de !== e.de) || (bus.o_hd_vsync !== xv) ||
          (bus.o_hd_hsync !== xh) || (bus.o_mode !== e.mode) ||
          (e.chkd && (bus.o_hd_d !== e.d)) || (e.due != cyc);
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL out@%0d: got de=%b vs=%b hs=%b mode=%0d d=%h, required de=%b vs=%b hs=%b mode=%0d d=%h (due %0d, data %s)",
               cyc, bus.o_hd_de, bus.o_hd_vsync, bus.o_hd_hsync, bus.o_mode,
               bus.o_hd_d, e.de, xv, xh, e.mode, e.d, e.due,
               e.chkd ? "checked" : "ignored");
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_v);
      while (sb.size() > 0 && sb[0].due <= cyc) chk(sb.pop_front());
    end
  end

  initial begin
    ex_t e;
    int  n;
    bus.i_mode  = 2'd0;
    bus.i_vsync = ~SA;
    bus.i_hsync = ~SA;
    bus.i_de    = 1'b0;
    bus.i_r     = '0;
    bus.i_g     = '0;
    bus.i_b     = '0;

    repeat (3) add(1, 0, 0, 0, 0, 0, 0, 0);
    idle(4, 0);
    add(0, 0, 0, 1, 0, 'h12, 'h34, 'h56);
    add(0, 0, 0, 1, 0, 'h12, 'h34, 'h56);
    idle(3, 0);
    vpulse(3, 1);
    idle(2, 0);
    add(0, 0, 0, 1, 0, 'hFF, 'hFF, 'hFF);
    add(0, 0, 0, 1, 0, 'hFF, 'h00, 'h00);
    idle(2, 0);
    vpulse(2, 2);
    idle(2, 2);
    rline(4, 2); idle(2, 2);
    rline(3, 2); idle(2, 2);
    rline(4, 2); idle(1, 2);
    rline(1, 2); idle(2, 2);
    rline(5, 2); idle(2, 2);
    vpulse(2, 0);
    idle(2, 2);
    rline(4, 2); idle(2, 2);
    vpulse(1, 2);
    idle(1, 2);
    rline(4, 2); idle(2, 2);
    vpulse(2, 3);
    idle(1, 3);
    rline(3, 2); idle(2, 0);
    add(0, 1, 0, 1, 1, 'h80, 'h40, 'h20);
    add(0, 1, 0, 1, 1, 'h10, 'hC0, 'hF0);
    idle(2, 0);
    vpulse(1, 2);
    idle(1, 0);
    rline(3, 2);
    add(1, 0, 0, 1, 2, 'h11, 'h22, 'h33);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 1, 2, $urandom_range(0, MX), $urandom_range(0, MX),
          $urandom_range(0, MX));
    idle(3, 0);

    for (int seg = 0; seg < 70; seg++) begin
      n = $urandom_range(0, 11);
      if (n == 0) repeat ($urandom_range(1, 2)) add(1, 0, 0, 1, 0, 1, 2, 3);
      else if (n <= 3) begin
        vpulse($urandom_range(1, 3), $urandom_range(0, 3));
        if (n == 3) rline($urandom_range(1, 6), $urandom_range(0, 3));
      end else rline($urandom_range(1, 8), $urandom_range(0, 3));
      idle($urandom_range(0, 3), $urandom_range(0, 3));
    end
    idle(10, 0);

    build_exp();

    for (int i = 0; i < stim.size(); i++) begin
      @(negedge clk_v);
      #1;
      rst         = stim[i].rst;
      bus.i_vsync = stim[i].vs ? SA : ~SA;
      bus.i_hsync = stim[i].hs ? SA : ~SA;
      bus.i_de    = stim[i].de;
      bus.i_mode  = stim[i].mode;
      bus.i_r     = DW'(stim[i].r);
      bus.i_g     = DW'(stim[i].g);
      bus.i_b     = DW'(stim[i].b);
      e = exps[i];
      if (stim[i].rst) begin
        sb.delete();
        e.due = cyc + 1;
      end else e.due = cyc + L;
      sb.push_back(e);
    end

    n = 0;
    while (sb.size() > 0 && n < 40) begin
      @(negedge clk_v);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected outputs never seen, required 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
